// File: rtl/change_replay.sv
// Value-change replayer: buffers {time,id,val,last} records and drives each onto sig_out at its timestamp.
// Optional CHANGE_REPLAY_STROBE_EN adds chg_strobe, a one-cycle pulse per applied record.
module change_replay #(
  parameter int NUM_SIGS   = 8,
  parameter int ID_W       = 3,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit INIT_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [TS_W-1:0]     rec_time,
  input  logic [ID_W-1:0]     rec_id,
  input  logic                rec_val,
  input  logic                rec_last,
  output logic [NUM_SIGS-1:0] sig_out,
  output logic [TS_W-1:0]     time_now,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef CHANGE_REPLAY_STROBE_EN
  ,
  output logic [NUM_SIGS-1:0] chg_strobe
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = TS_W + ID_W + 2;
  localparam logic [AW:0]          FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [NUM_SIGS-1:0]  INIT_VEC = {NUM_SIGS{INIT_VAL}};
  localparam logic [TS_W-1:0]      TS_ZERO  = {TS_W{1'b0}};
  localparam logic [TS_W-1:0]      TS_MAX   = {TS_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [RW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_r, rd_ptr_r, count_s, count_nxt_s;
  logic                push_s, pop_s;
  logic [RW-1:0]       head_s;
  logic [TS_W-1:0]     head_time_s;
  logic [ID_W-1:0]     head_id_s;
  logic                head_val_s, head_last_s;
  logic [NUM_SIGS-1:0] sig_nxt_s;
  logic [TS_W-1:0]     time_nxt_s;
  logic                err_nxt_s;
`ifdef CHANGE_REPLAY_STROBE_EN
  logic [NUM_SIGS-1:0] strobe_nxt_s;
`endif

  // Local time saturates at the top of its range instead of wrapping.
  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] t);
    if (t == TS_MAX) sat_inc = t;
    else             sat_inc = t + {{(TS_W-1){1'b0}}, 1'b1};
  endfunction

  // FIFO handshake and head-record field decode
  always_comb begin
    push_s      = rec_valid && rec_ready;
    count_s     = wr_ptr_r - rd_ptr_r;
    head_s      = mem_r[rd_ptr_r[AW-1:0]];
    head_time_s = head_s[RW-1 -: TS_W];
    head_id_s   = head_s[ID_W+1:2];
    head_val_s  = head_s[1];
    head_last_s = head_s[0];
  end

  // Replay engine: restart handling and one head-record evaluation per cycle
  always_comb begin
    state_nxt_s = state_r;
    sig_nxt_s   = sig_out;
    time_nxt_s  = time_now;
    err_nxt_s   = err;
    pop_s       = 1'b0;
`ifdef CHANGE_REPLAY_STROBE_EN
    strobe_nxt_s = {NUM_SIGS{1'b0}};
`endif
    if (start) begin
      state_nxt_s = RUN;
      time_nxt_s  = TS_ZERO;
      sig_nxt_s   = INIT_VEC;
      err_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (count_s == {(AW+1){1'b0}}) begin
            time_nxt_s = sat_inc(time_now);
          end else if (32'(head_id_s) >= NUM_SIGS) begin
            pop_s     = 1'b1;
            err_nxt_s = 1'b1;
          end else if (head_time_s < time_now) begin
            pop_s     = 1'b1;
            err_nxt_s = 1'b1;
          end else if (head_time_s == time_now) begin
            pop_s = 1'b1;
            for (int i = 0; i < NUM_SIGS; i++) begin
              sig_nxt_s[i] = (32'(head_id_s) == i) ? head_val_s : sig_out[i];
`ifdef CHANGE_REPLAY_STROBE_EN
              strobe_nxt_s[i] = (32'(head_id_s) == i);
`endif
            end
          end else begin
            time_nxt_s = sat_inc(time_now);
          end
          // A last record ends the replay whether it was applied or discarded.
          if (pop_s && head_last_s) state_nxt_s = DONE;
          else                      state_nxt_s = RUN;
        end
        IDLE:    time_nxt_s  = TS_ZERO;
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
    count_nxt_s = count_s + (AW+1)'(push_s) - (AW+1)'(pop_s);
  end

  // State, pointers and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      wr_ptr_r  <= {(AW+1){1'b0}};
      rd_ptr_r  <= {(AW+1){1'b0}};
      sig_out   <= INIT_VEC;
      time_now  <= TS_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rec_ready <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      sig_out   <= sig_nxt_s;
      time_now  <= time_nxt_s;
      err       <= err_nxt_s;
      busy      <= (state_nxt_s == RUN);
      done      <= (state_nxt_s == DONE);
      rec_ready <= (count_nxt_s != FULL_CNT) && (state_nxt_s != DONE);
    end
  end

  // Record storage; occupancy is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= {rec_time, rec_id, rec_val, rec_last};
  end

`ifdef CHANGE_REPLAY_STROBE_EN
  // Strobe register, aligned with the sig_out update it marks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chg_strobe <= {NUM_SIGS{1'b0}};
    else     chg_strobe <= strobe_nxt_s;
  end
`endif

endmodule

// File: tb/tb_change_replay.sv
// Scoreboard bench for change_replay: a reference model predicts every sig_out change with its time_now.
module tb_change_replay;
  localparam logic [7:0] INIT = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, rec_valid = 1'b0, rec_val = 1'b0, rec_last = 1'b0, rec_ready;
  logic [15:0] rec_time = 16'h0, time_now;
  logic [2:0]  rec_id = 3'h0;
  logic [7:0]  sig_out;
  logic busy, done, err;

  logic start1 = 1'b0, rec_valid1 = 1'b0, rec_val1 = 1'b0, rec_last1 = 1'b0, rec_ready1;
  logic [15:0] rec_time1 = 16'h0, time_now1;
  logic [2:0]  rec_id1 = 3'h0;
  logic [3:0]  sig_out1;
  logic busy1, done1, err1;

  int checks = 0, errors = 0, spurious = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  msig = INIT, prev_sig = INIT;
  logic [15:0] mtime = 16'h0;
  logic        merr = 1'b0;

  change_replay u0 (
    .clk(clk), .rst(rst), .start(start), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_time(rec_time), .rec_id(rec_id), .rec_val(rec_val), .rec_last(rec_last),
    .sig_out(sig_out), .time_now(time_now), .busy(busy), .done(done), .err(err)
`ifdef CHANGE_REPLAY_STROBE_EN
    , .chg_strobe()
`endif
  );

  change_replay #(.NUM_SIGS(4), .ID_W(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .rec_valid(rec_valid1), .rec_ready(rec_ready1),
    .rec_time(rec_time1), .rec_id(rec_id1), .rec_val(rec_val1), .rec_last(rec_last1),
    .sig_out(sig_out1), .time_now(time_now1), .busy(busy1), .done(done1), .err(err1)
`ifdef CHANGE_REPLAY_STROBE_EN
    , .chg_strobe()
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Every sig_out change must match the next predicted {time_now, sig_out}.
  always @(negedge clk) begin
    if (rst) prev_sig = sig_out;
    else if (sig_out !== prev_sig) begin
      if (exp_q.size() == 0) begin
        spurious++;
        $display("FAIL sig_change: got unexpected %0h at time_now %0d", sig_out, time_now);
      end else check("sig_change", {8'h00, time_now, sig_out}, exp_q.pop_front());
      prev_sig = sig_out;
    end
  end

  task automatic model_rec(input logic [15:0] t, input logic [2:0] id, input logic v);
    logic [7:0] nsig;
    if (t < mtime) merr = 1'b1;
    else begin
      mtime = t;
      nsig = msig;
      nsig[id] = v;
      if (nsig != msig) exp_q.push_back({8'h00, t, nsig});
      msig = nsig;
    end
  endtask

  task automatic model_start();
    mtime = 16'h0;
    merr  = 1'b0;
    if (msig != INIT) exp_q.push_back({8'h00, 16'h0, INIT});
    msig = INIT;
  endtask

  task automatic push_rec(input logic [15:0] t, input logic [2:0] id, input logic v, input logic l);
    int n = 0;
    @(negedge clk);
    rec_valid = 1'b1; rec_time = t; rec_id = id; rec_val = v; rec_last = l;
    while (!rec_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(rec_ready), 32'd1);
    @(posedge clk);
    #1 rec_valid = 1'b0;
    model_rec(t, id, v);
  endtask

  task automatic push1(input logic [15:0] t, input logic [2:0] id, input logic v, input logic l);
    int n = 0;
    @(negedge clk);
    rec_valid1 = 1'b1; rec_time1 = t; rec_id1 = id; rec_val1 = v; rec_last1 = l;
    while (!rec_ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push1_ready", 32'(rec_ready1), 32'd1);
    @(posedge clk);
    #1 rec_valid1 = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_sig",   32'(sig_out), 32'(INIT));
    check("rst_time",  32'(time_now), 32'd0);
    check("rst_flags", {28'h0, busy, done, err, rec_ready}, 32'd0);
    exp_q.delete();
    msig = INIT; mtime = 16'h0; merr = 1'b0;
    start = 1'b0; rec_valid = 1'b0; start1 = 1'b0; rec_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_pre", 32'(rec_ready), 32'd0);
    @(negedge clk);
    check("ready_post", 32'(rec_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    // basic set then clear of one signal
    do_reset();
    push_rec(16'd3, 3'd2, 1'b1, 1'b0);
    push_rec(16'd5, 3'd2, 1'b0, 1'b1);
    do_start();
    wait_done(50);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
    check("t1_err", 32'(err), 32'(merr));
    check("t1_time", 32'(time_now), 32'd5);
    check("t1_done_flags", {30'h0, busy, rec_ready}, 32'd0);

    // equal timestamps apply on consecutive cycles
    do_reset();
    push_rec(16'd4, 3'd0, 1'b1, 1'b0);
    push_rec(16'd4, 3'd1, 1'b1, 1'b0);
    push_rec(16'd4, 3'd7, 1'b1, 1'b1);
    do_start();
    wait_done(50);
    check("t2_pending", 32'(exp_q.size()), 32'd0);
    check("t2_sig", 32'(sig_out), 32'(msig));
    check("t2_time", 32'(time_now), 32'd4);

    // late record discarded, err sticky until restart
    do_reset();
    push_rec(16'd6, 3'd1, 1'b1, 1'b0);
    push_rec(16'd2, 3'd3, 1'b1, 1'b1);
    do_start();
    wait_done(50);
    check("t3_err", 32'(err), 32'(merr));
    check("t3_sig", 32'(sig_out), 32'(msig));
    model_start();
    do_start();
    repeat (2) @(negedge clk);
    check("t3_err_clr", 32'(err), 32'(merr));
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_pending", 32'(exp_q.size()), 32'd0);

    // backpressure: FIFO full behind a far-future head
    do_reset();
    for (int i = 0; i < 4; i++) push_rec(16'(100 + i), 3'(i), 1'b1, 1'b0);
    @(negedge clk);
    check("t4_full", 32'(rec_ready), 32'd0);
    do_start();
    repeat (5) @(negedge clk);
    check("t4_full_run", 32'(rec_ready), 32'd0);
    push_rec(16'd104, 3'd4, 1'b1, 1'b0);
    push_rec(16'd105, 3'd5, 1'b1, 1'b1);
    wait_done(300);
    check("t4_pending", 32'(exp_q.size()), 32'd0);
    check("t4_sig", 32'(sig_out), 32'(msig));
    check("t4_time", 32'(time_now), 32'd105);

    // out-of-range id on a 4-signal instance
    push1(16'd1, 3'd5, 1'b1, 1'b0);
    push1(16'd2, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 0; n < 50 && !done1; n++) @(negedge clk);
    check("t5_done", 32'(done1), 32'd1);
    check("t5_err", 32'(err1), 32'd1);
    check("t5_sig", 32'(sig_out1), 32'h1);
    check("t5_time", 32'(time_now1), 32'd2);

    // reset mid-replay empties the FIFO
    do_reset();
    push_rec(16'd50, 3'd0, 1'b1, 1'b0);
    push_rec(16'd60, 3'd1, 1'b1, 1'b0);
    push_rec(16'd70, 3'd2, 1'b1, 1'b0);
    do_start();
    repeat (10) @(negedge clk);
    check("t6_busy", 32'(busy), 32'd1);
    do_reset();
    do_start();
    repeat (80) @(negedge clk);
    check("t6_sig", 32'(sig_out), 32'(INIT));
    check("t6_done", 32'(done), 32'd0);
    check("t6_time_adv", 32'(time_now > 16'd70), 32'd1);
    check("spurious", 32'(spurious), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
